// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous RAM, with a 2-entry output queue hiding read latency.
// Optional high-watermark output enabled by defining RAM_FIFO_CTRL_PEAK_EN.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  empty,
    output logic                  full
`ifdef RAM_FIFO_CTRL_PEAK_EN
    ,
    input  logic                  peak_clr,
    output logic [ADDR_WIDTH+1:0] peak
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic                  rd_inflight;
    logic [1:0]            oq_cnt;
    logic [DATA_WIDTH-1:0] oq0;
    logic [DATA_WIDTH-1:0] oq1;

    logic                  pop;
    logic [2:0]            slots_used;
    logic                  mem_full;
    logic                  rd_issue;
    logic                  wr;
    logic [1:0]            tail;
    logic [1:0]            oq_cnt_nxt;
    logic [DATA_WIDTH-1:0] oq0_nxt;
    logic [DATA_WIDTH-1:0] oq1_nxt;

    assign pop        = out_valid && out_ready;
    assign slots_used = {1'b0, oq_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign mem_full   = (mem_cnt == MEM_FULL);

    // A read only wins the port when the out queue would otherwise drain, or the RAM cannot take a write.
    assign rd_issue = (mem_cnt != '0) && (slots_used < 3'd2) &&
                      ((slots_used == 3'd0) || !in_valid || mem_full);
    assign in_ready = rst_n && !mem_full && !rd_issue;
    assign wr       = in_valid && in_ready;

    assign ram_we   = wr;
    assign ram_addr = rd_issue ? rd_ptr : wr_ptr;
    assign ram_din  = in_data;

    assign out_valid = (oq_cnt != 2'd0);
    assign out_data  = oq0;

    assign count = {1'b0, mem_cnt} + {{(ADDR_WIDTH + 1){1'b0}}, rd_inflight}
                 + {{ADDR_WIDTH{1'b0}}, oq_cnt};
    assign empty = (count == '0);
    assign full  = mem_full;

    assign tail       = oq_cnt - {1'b0, pop};
    assign oq_cnt_nxt = oq_cnt + {1'b0, rd_inflight} - {1'b0, pop};

    // Shift on pop first, then land the returning RAM word at the post-pop tail so order is kept.
    always_comb begin
        oq0_nxt = oq0;
        oq1_nxt = oq1;
        if (pop) begin
            oq0_nxt = oq1;
        end
        if (rd_inflight) begin
            if (tail == 2'd0) begin
                oq0_nxt = ram_dout;
            end else begin
                oq1_nxt = ram_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            rd_inflight <= 1'b0;
            oq_cnt      <= 2'd0;
            oq0         <= '0;
            oq1         <= '0;
        end else begin
            if (wr) begin
                wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
                mem_cnt <= mem_cnt + (ADDR_WIDTH + 1)'(1);
            end else if (rd_issue) begin
                mem_cnt <= mem_cnt - (ADDR_WIDTH + 1)'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            rd_inflight <= rd_issue;
            oq_cnt      <= oq_cnt_nxt;
            oq0         <= oq0_nxt;
            oq1         <= oq1_nxt;
        end
    end

`ifdef RAM_FIFO_CTRL_PEAK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (peak_clr) begin
            peak <= '0;
        end else if (count > peak) begin
            peak <= count;
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port synchronous RAM and a scoreboard queue.
module tb_ram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [AW+1:0] count;
    logic          empty;
    logic          full;
`ifdef RAM_FIFO_CTRL_PEAK_EN
    logic          peak_clr;
    logic [AW+1:0] peak;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];
    int  wp;
    logic acc;
    logic popd;
    int  n;
    int  cyc;

    logic [DW-1:0] mem [2**AW];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .count(count), .empty(empty), .full(full)
`ifdef RAM_FIFO_CTRL_PEAK_EN
        , .peak_clr(peak_clr), .peak(peak)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later, book handshakes against the scoreboard.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy);
        logic [DW-1:0] exp_d;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        check("count", 32'(count), 32'(sb.size()));
        acc  = in_valid && in_ready;
        popd = out_valid && out_ready;
        check("ram_we", 32'(ram_we), 32'(acc));
        if (acc) begin
            check("wr_addr", 32'(ram_addr), 32'(wp % (2**AW)));
            check("ram_din", 32'(ram_din), 32'(id));
            wp++;
        end
        if (popd) begin
            if (sb.size() == 0) begin
                check("pop_underflow", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_d = sb.pop_front();
                check("pop_data", 32'(out_data), 32'(exp_d));
            end
        end
        if (acc) sb.push_back(id);
    endtask

    task automatic fill(input int words, input logic [DW-1:0] base);
        int k = 0;
        for (int c = 0; c < 400 && k < words; c++) begin
            step(1'b1, base + DW'(k), 1'b0);
            if (acc) k++;
        end
        check("fill_done", 32'(k), 32'(words));
    endtask

    task automatic drain(output int cycles);
        cycles = 0;
        for (int c = 0; c < 400 && sb.size() > 0; c++) begin
            step(1'b0, '0, 1'b1);
            cycles++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef RAM_FIFO_CTRL_PEAK_EN
        peak_clr  = 1'b0;
`endif
        wp = 0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word: acceptance, two-cycle latency to out_valid.
        step(1'b1, 8'hA5, 1'b0);
        check("t1_acc", 32'(acc), 32'd1);
        step(1'b0, '0, 1'b0);
        check("t1_ov_e1", 32'(out_valid), 32'd0);
        step(1'b0, '0, 1'b0);
        check("t1_ov_e2", 32'(out_valid), 32'd0);
        step(1'b0, '0, 1'b0);
        check("t1_ov_e3", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'hA5);
        check("t1_empty", 32'(empty), 32'd0);
        step(1'b0, '0, 1'b1);
        check("t1_popped", 32'(popd), 32'd1);
        step(1'b0, '0, 1'b0);
        check("t1_empty_after", 32'(empty), 32'd1);
        check("t1_ov_after", 32'(out_valid), 32'd0);

        // Fill to total capacity DEPTH+2, confirm backpressure, drain at one word per cycle.
        fill(18, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hEE, 1'b0);
            check("t2_in_ready_full", 32'(in_ready), 32'd0);
            check("t2_full", 32'(full), 32'd1);
        end
        drain(cyc);
        check("t2_drain_rate", 32'(cyc), 32'd18);
        step(1'b0, '0, 1'b0);
        check("t2_empty", 32'(empty), 32'd1);
        check("t2_full_clr", 32'(full), 32'd0);

        // Continuous push and pop of 100 words.
        n = 0;
        for (int c = 0; c < 1000 && n < 100; c++) begin
            step(1'b1, 8'(n + 8'h20), 1'b1);
            if (acc) n++;
        end
        check("t3_pushed", 32'(n), 32'd100);
        drain(cyc);
        step(1'b0, '0, 1'b0);
        check("t3_empty", 32'(empty), 32'd1);

        // Three fill/drain rounds through pointer wrap.
        for (int r = 0; r < 3; r++) begin
            fill(16, 8'(8'h80 + r * 16));
            step(1'b0, '0, 1'b0);
            drain(cyc);
        end
        step(1'b0, '0, 1'b0);
        check("t4_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream with seven words held.
        fill(7, 8'h60);
        step(1'b0, '0, 1'b0);
        check("t5_pre_count", 32'(count), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ov", 32'(out_valid), 32'd0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_ram_we", 32'(ram_we), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        sb.delete();
        wp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        fill(1, 8'h3C);
        for (int c = 0; c < 20 && !out_valid; c++) step(1'b0, '0, 1'b0);
        check("t5_first", 32'(out_data), 32'h3C);
        drain(cyc);

`ifdef RAM_FIFO_CTRL_PEAK_EN
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        fill(10, 8'hC0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        drain(cyc);
        step(1'b0, '0, 1'b0);
        check("t6_peak", 32'(peak), 32'd10);
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        #1;
        check("t6_peak_clr", 32'(peak), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
